// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: valid/ready buffer placed between two pipeline stages.
// Holds up to DEPTH payloads in strict FIFO order. data_out is always taken
// from a register (no fall-through), so a push is visible one cycle later.
// A flush empties the buffer in one cycle and blocks both handshakes while
// it is high. PASS=1 lets a full buffer accept a new payload in the same
// cycle that the consumer takes the head entry.
module pipe_stage_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PASS   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic             PASS_EN  = (PASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // While flushing neither handshake may complete. With PASS=1 a full
    // buffer still accepts when the head is leaving in the same cycle.
    assign ready_out = !flush && (!full || (PASS_EN && ready_in));
    assign valid_out = !empty && !flush;
    assign data_out  = mem[rd_ptr];

    assign push = valid_in && ready_out;
    assign pop  = valid_out && ready_in;

    // Payload storage; cleared on reset so data_out reads zero while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy tracking; flush returns everything to empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo. Three instances run off a shared clock
// and reset: a (DEPTH=2, PASS=0), b (DEPTH=2, PASS=1), c (DEPTH=3, PASS=0).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge, or straight after an asynchronous reset assertion.
module tb_pipe_stage_fifo;

    logic clk;
    logic rst;
    int   npass;
    int   ntotal;

    logic        fl_a, iv_a, ro_a, vo_a, ri_a, fu_a, em_a;
    logic [31:0] di_a, do_a;
    logic [1:0]  cn_a;

    logic        fl_b, iv_b, ro_b, vo_b, ri_b, fu_b, em_b;
    logic [31:0] di_b, do_b;
    logic [1:0]  cn_b;

    logic        fl_c, iv_c, ro_c, vo_c, ri_c, fu_c, em_c;
    logic [31:0] di_c, do_c;
    logic [1:0]  cn_c;

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(2), .PASS(0)) u_a (
        .clk(clk), .rst(rst), .flush(fl_a), .valid_in(iv_a), .ready_out(ro_a),
        .data_in(di_a), .valid_out(vo_a), .ready_in(ri_a), .data_out(do_a),
        .count(cn_a), .full(fu_a), .empty(em_a));

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(2), .PASS(1)) u_b (
        .clk(clk), .rst(rst), .flush(fl_b), .valid_in(iv_b), .ready_out(ro_b),
        .data_in(di_b), .valid_out(vo_b), .ready_in(ri_b), .data_out(do_b),
        .count(cn_b), .full(fu_b), .empty(em_b));

    pipe_stage_fifo #(.DATA_W(32), .DEPTH(3), .PASS(0)) u_c (
        .clk(clk), .rst(rst), .flush(fl_c), .valid_in(iv_c), .ready_out(ro_c),
        .data_in(di_c), .valid_out(vo_c), .ready_in(ri_c), .data_out(do_c),
        .count(cn_c), .full(fu_c), .empty(em_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ntotal++; if (vo_a !== 1'b0) $display("FAIL rst_valid_a: got %b want 0", vo_a); else npass++;
        ntotal++; if (em_a !== 1'b1) $display("FAIL rst_empty_a: got %b want 1", em_a); else npass++;
        ntotal++; if (fu_a !== 1'b0) $display("FAIL rst_full_a: got %b want 0", fu_a); else npass++;
        ntotal++; if (cn_a !== 2'd0) $display("FAIL rst_count_a: got %0d want 0", cn_a); else npass++;
        ntotal++; if (do_a !== 32'h0) $display("FAIL rst_data_a: got %h want 0", do_a); else npass++;
        ntotal++; if (ro_a !== 1'b1) $display("FAIL rst_ready_a: got %b want 1", ro_a); else npass++;
        ntotal++; if (vo_b !== 1'b0) $display("FAIL rst_valid_b: got %b want 0", vo_b); else npass++;
        ntotal++; if (vo_c !== 1'b0) $display("FAIL rst_valid_c: got %b want 0", vo_c); else npass++;
        ntotal++; if (em_c !== 1'b1) $display("FAIL rst_empty_c: got %b want 1", em_c); else npass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        iv_a = 1'b1; di_a = 32'hA5A5_0001;
        @(negedge clk);
        ntotal++; if (vo_a !== 1'b0) $display("FAIL lat_valid_c0: got %b want 0", vo_a); else npass++;
        ntotal++; if (ro_a !== 1'b1) $display("FAIL lat_ready_c0: got %b want 1", ro_a); else npass++;
        tick();
        iv_a = 1'b0;
        @(negedge clk);
        ntotal++; if (vo_a !== 1'b1) $display("FAIL lat_valid_c1: got %b want 1", vo_a); else npass++;
        ntotal++; if (do_a !== 32'hA5A5_0001) $display("FAIL lat_data_c1: got %h want a5a50001", do_a); else npass++;
        ntotal++; if (cn_a !== 2'd1) $display("FAIL lat_count_c1: got %0d want 1", cn_a); else npass++;
        tick();
        ri_a = 1'b1;
        tick();
        ri_a = 1'b0;
        @(negedge clk);
        ntotal++; if (em_a !== 1'b1) $display("FAIL lat_drain_empty: got %b want 1", em_a); else npass++;
        tick();
    endtask

    task automatic test_fill_drain();
        ri_a = 1'b0;
        iv_a = 1'b1; di_a = 32'h0001;
        tick();
        di_a = 32'h0002;
        tick();
        di_a = 32'h0003;
        @(negedge clk);
        ntotal++; if (cn_a !== 2'd2) $display("FAIL fill_count: got %0d want 2", cn_a); else npass++;
        ntotal++; if (fu_a !== 1'b1) $display("FAIL fill_full: got %b want 1", fu_a); else npass++;
        ntotal++; if (ro_a !== 1'b0) $display("FAIL fill_ready: got %b want 0", ro_a); else npass++;
        tick();
        ntotal++; if (cn_a !== 2'd2) $display("FAIL fill_hold_count: got %0d want 2", cn_a); else npass++;
        iv_a = 1'b0;
        ri_a = 1'b1;
        @(negedge clk);
        ntotal++; if (do_a !== 32'h0001) $display("FAIL drain_first: got %h want 00000001", do_a); else npass++;
        tick();
        @(negedge clk);
        ntotal++; if (do_a !== 32'h0002) $display("FAIL drain_second: got %h want 00000002", do_a); else npass++;
        ntotal++; if (vo_a !== 1'b1) $display("FAIL drain_second_valid: got %b want 1", vo_a); else npass++;
        tick();
        @(negedge clk);
        ntotal++; if (em_a !== 1'b1) $display("FAIL drain_empty: got %b want 1", em_a); else npass++;
        ntotal++; if (vo_a !== 1'b0) $display("FAIL drain_valid_low: got %b want 0", vo_a); else npass++;
        ri_a = 1'b0;
        tick();
    endtask

    task automatic test_pass_through();
        logic [31:0] exp_q [6];
        exp_q = '{32'h1, 32'h2, 32'h10, 32'h11, 32'h12, 32'h13};
        ri_b = 1'b0;
        iv_b = 1'b1; di_b = 32'h0001;
        tick();
        di_b = 32'h0002;
        tick();
        ri_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            di_b = 32'h10 + 32'(i);
            @(negedge clk);
            ntotal++; if (ro_b !== 1'b1) $display("FAIL pass_ready[%0d]: got %b want 1", i, ro_b); else npass++;
            ntotal++; if (cn_b !== 2'd2) $display("FAIL pass_count[%0d]: got %0d want 2", i, cn_b); else npass++;
            ntotal++; if (do_b !== exp_q[i]) $display("FAIL pass_data[%0d]: got %h want %h", i, do_b, exp_q[i]); else npass++;
            tick();
        end
        iv_b = 1'b0;
        for (int i = 4; i < 6; i++) begin
            @(negedge clk);
            ntotal++; if (do_b !== exp_q[i]) $display("FAIL pass_tail[%0d]: got %h want %h", i, do_b, exp_q[i]); else npass++;
            tick();
        end
        @(negedge clk);
        ntotal++; if (em_b !== 1'b1) $display("FAIL pass_empty: got %b want 1", em_b); else npass++;
        ri_b = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ri_a = 1'b0;
        iv_a = 1'b1; di_a = 32'h0001;
        tick();
        di_a = 32'h0002;
        tick();
        fl_a = 1'b1; ri_a = 1'b1; di_a = 32'hDEAD;
        @(negedge clk);
        ntotal++; if (ro_a !== 1'b0) $display("FAIL flush_ready: got %b want 0", ro_a); else npass++;
        ntotal++; if (vo_a !== 1'b0) $display("FAIL flush_valid: got %b want 0", vo_a); else npass++;
        tick();
        fl_a = 1'b0; iv_a = 1'b0; ri_a = 1'b0;
        @(negedge clk);
        ntotal++; if (cn_a !== 2'd0) $display("FAIL flush_count: got %0d want 0", cn_a); else npass++;
        ntotal++; if (em_a !== 1'b1) $display("FAIL flush_empty: got %b want 1", em_a); else npass++;
        ntotal++; if (vo_a !== 1'b0) $display("FAIL flush_after_valid: got %b want 0", vo_a); else npass++;
        tick();
        iv_a = 1'b1; di_a = 32'h77;
        tick();
        iv_a = 1'b0;
        @(negedge clk);
        ntotal++; if (do_a !== 32'h77) $display("FAIL flush_next_data: got %h want 00000077", do_a); else npass++;
        ntotal++; if (cn_a !== 2'd1) $display("FAIL flush_next_count: got %0d want 1", cn_a); else npass++;
        ri_a = 1'b1;
        tick();
        ri_a = 1'b0;
    endtask

    task automatic test_stream_wrap();
        int nxt = 1;
        int exp_rd = 1;
        int mcnt = 0;
        int cyc = 0;
        logic [7:0] lfsr = 8'hA7;
        logic push, pop;
        while (exp_rd <= 10 && cyc < 300) begin
            iv_c = (nxt <= 10);
            di_c = 32'(nxt);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ri_c = lfsr[0];
            @(negedge clk);
            push = iv_c && (mcnt < 3);
            pop  = (mcnt > 0) && ri_c;
            ntotal++; if (cn_c !== 2'(mcnt)) $display("FAIL stream_count@%0d: got %0d want %0d", cyc, cn_c, mcnt); else npass++;
            ntotal++; if (ro_c !== (mcnt < 3)) $display("FAIL stream_ready@%0d: got %b want %b", cyc, ro_c, (mcnt < 3)); else npass++;
            ntotal++; if (vo_c !== (mcnt > 0)) $display("FAIL stream_valid@%0d: got %b want %b", cyc, vo_c, (mcnt > 0)); else npass++;
            if (pop) begin
                ntotal++; if (do_c !== 32'(exp_rd)) $display("FAIL stream_data@%0d: got %0d want %0d", cyc, do_c, exp_rd); else npass++;
            end
            tick();
            if (push) begin nxt++; mcnt++; end
            if (pop) begin exp_rd++; mcnt--; end
            cyc++;
        end
        ntotal++; if (exp_rd != 11) $display("FAIL stream_timeout: got %0d words want 10", exp_rd - 1); else npass++;
        iv_c = 1'b0; ri_c = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        ri_a = 1'b0;
        iv_a = 1'b1; di_a = 32'h0011;
        tick();
        di_a = 32'h0022;
        tick();
        iv_a = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        ntotal++; if (vo_a !== 1'b0) $display("FAIL arst_valid: got %b want 0", vo_a); else npass++;
        ntotal++; if (cn_a !== 2'd0) $display("FAIL arst_count: got %0d want 0", cn_a); else npass++;
        ntotal++; if (do_a !== 32'h0) $display("FAIL arst_data: got %h want 0", do_a); else npass++;
        ntotal++; if (ro_a !== 1'b1) $display("FAIL arst_ready: got %b want 1", ro_a); else npass++;
        @(negedge clk);
        rst = 1'b1;
        iv_a = 1'b1; di_a = 32'h55;
        tick();
        iv_a = 1'b0;
        @(negedge clk);
        ntotal++; if (vo_a !== 1'b1) $display("FAIL arst_push_valid: got %b want 1", vo_a); else npass++;
        ntotal++; if (do_a !== 32'h55) $display("FAIL arst_push_data: got %h want 00000055", do_a); else npass++;
        tick();
    endtask

    initial begin
        npass = 0; ntotal = 0;
        rst = 1'b0;
        fl_a = 0; iv_a = 0; ri_a = 0; di_a = '0;
        fl_b = 0; iv_b = 0; ri_b = 0; di_b = '0;
        fl_c = 0; iv_c = 0; ri_c = 0; di_c = '0;
        #2;
        test_reset();
        test_latency();
        test_fill_drain();
        test_pass_through();
        test_flush();
        test_stream_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
